// File: rtl/lcd_driver.sv
// HD44780 8-bit write-only driver: runs the power-up init sequence itself,
// then performs one timed command/character write per enable_lcd request.
module lcd_driver #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned PULSE_CYCLES   = 25,
  parameter int unsigned EXEC_CYCLES    = 2500,
  parameter int unsigned CLEAR_CYCLES   = 82000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_lcd,
  input  logic [7:0] lcd_in_data,
  input  logic       lcd_in_rs,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    SETUP,
    PULSE,
    HOLD_WAIT,
    IDLE
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PUL_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXE_LAST = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx, idx_n;
  logic             init_active, init_n;
  logic [7:0]       data_n;
  logic             rs_n;
  logic             done_n;
  logic             overrun_n;
  logic             long_wait;
  logic [CNT_W-1:0] wait_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    unique case (i)
      2'd0:    c = 8'h38;
      2'd1:    c = 8'h0C;
      2'd2:    c = 8'h06;
      default: c = 8'h01;
    endcase
    return c;
  endfunction

  assign lcd_rw = 1'b0;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  assign long_wait = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data != 8'd0);
  assign wait_last = long_wait ? CLR_LAST : EXE_LAST;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    idx_n     = idx;
    init_n    = init_active;
    data_n    = lcd_data;
    rs_n      = lcd_rs;
    done_n    = 1'b0;
    overrun_n = enable_lcd && busy;
    unique case (state)
      PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          state_n = SETUP;
          cnt_n   = '0;
          data_n  = init_cmd(idx);
          rs_n    = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == SET_LAST) begin
          state_n = PULSE;
          cnt_n   = '0;
        end
      end
      PULSE: begin
        if (cnt == PUL_LAST) begin
          state_n = HOLD_WAIT;
          cnt_n   = '0;
        end
      end
      HOLD_WAIT: begin
        if (cnt == wait_last) begin
          cnt_n = '0;
          if (!init_active) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (idx == 2'd3) begin
            state_n = IDLE;
            init_n  = 1'b0;
          end else begin
            state_n = SETUP;
            idx_n   = idx + 2'd1;
            data_n  = init_cmd(idx + 2'd1);
            rs_n    = 1'b0;
          end
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (enable_lcd) begin
          state_n = SETUP;
          data_n  = lcd_in_data;
          rs_n    = lcd_in_rs;
        end
      end
      default: begin
        state_n = PWR_WAIT;
        cnt_n   = '0;
      end
    endcase
  end

  // busy and lcd_e are registered from the next state to keep E glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PWR_WAIT;
      cnt         <= '0;
      idx         <= 2'd0;
      init_active <= 1'b1;
      lcd_data    <= 8'h00;
      lcd_rs      <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b1;
      lcd_e       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      init_active <= init_n;
      lcd_data    <= data_n;
      lcd_rs      <= rs_n;
      done        <= done_n;
      overrun     <= overrun_n;
      busy        <= (state_n != IDLE);
      lcd_e       <= (state_n == PULSE);
    end
  end

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver: vector table plus hand sequences, with a
// scoreboard of expected E-pulse bytes checked by a bus monitor.
module tb_lcd_driver;

  logic       clk;
  logic       rst;
  logic       enable_lcd;
  logic [7:0] lcd_in_data;
  logic       lcd_in_rs;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  lcd_driver #(
    .POWERUP_CYCLES(10),
    .SETUP_CYCLES(2),
    .PULSE_CYCLES(3),
    .EXEC_CYCLES(5),
    .CLEAR_CYCLES(20),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_lcd(enable_lcd),
    .lcd_in_data(lcd_in_data),
    .lcd_in_rs(lcd_in_rs),
    .busy(busy),
    .done(done),
    .overrun(overrun),
    .lcd_data(lcd_data),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_e(lcd_e)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       rs;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         lat;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   width = 0;
  int   done_cnt = 0;
  logic e_prev = 1'b0;
  logic cut = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus monitor: every E rising edge must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (lcd_e === 1'b1 && !e_prev) begin
      rise_cyc = cyc;
      width = 1;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_e: data %0h rs %0b", lcd_data, lcd_rs);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("e_data", {24'd0, lcd_data}, {24'd0, e.d});
        chk("e_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
        chk("e_rw", {31'd0, lcd_rw}, 32'd0);
      end
    end else if (lcd_e === 1'b1) begin
      width++;
    end else if (e_prev) begin
      if (cut) cut = 1'b0;
      else chk("e_width", width, 3);
    end
    e_prev = (lcd_e === 1'b1);
    if (done === 1'b1) done_cnt++;
  end

  task automatic push_init();
    sbq.push_back('{d: 8'h38, rs: 1'b0});
    sbq.push_back('{d: 8'h0C, rs: 1'b0});
    sbq.push_back('{d: 8'h06, rs: 1'b0});
    sbq.push_back('{d: 8'h01, rs: 1'b0});
  endtask

  // Counts busy cycles from the cycle after the last reset edge.
  task automatic run_init(input int ovr_at, output int n);
    n = 1;
    for (int k = 0; k < 200 && busy === 1'b1; k++) begin
      enable_lcd  = (k == ovr_at);
      lcd_in_data = 8'hAA;
      lcd_in_rs   = 1'b1;
      tick();
      if (k == ovr_at) chk("init_overrun", {31'd0, overrun}, 32'd1);
      if (busy === 1'b1) n++;
    end
    enable_lcd = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 200) begin
      tick();
      k++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy %0b expected 0", busy);
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    vec_t vecs[8];
    int   n;
    int   lat;
    int   t_acc;
    int   d0;

    vecs[0] = '{data: 8'h41, rs: 1'b1, lat: 11};
    vecs[1] = '{data: 8'h01, rs: 1'b0, lat: 26};
    vecs[2] = '{data: 8'h80, rs: 1'b0, lat: 11};
    vecs[3] = '{data: 8'h02, rs: 1'b0, lat: 26};
    vecs[4] = '{data: 8'h03, rs: 1'b0, lat: 26};
    vecs[5] = '{data: 8'h00, rs: 1'b0, lat: 11};
    vecs[6] = '{data: 8'h04, rs: 1'b0, lat: 11};
    vecs[7] = '{data: 8'h01, rs: 1'b1, lat: 11};

    rst = 1'b1;
    enable_lcd = 1'b0;
    lcd_in_data = 8'h00;
    lcd_in_rs = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);

    push_init();
    rst = 1'b0;
    run_init(30, n);
    chk("init_busy_len", n, 65);
    chk("init_no_done", done_cnt, 0);
    chk("init_sb_drained", sbq.size(), 0);

    foreach (vecs[i]) begin
      wait_idle();
      enable_lcd  = 1'b1;
      lcd_in_data = vecs[i].data;
      lcd_in_rs   = vecs[i].rs;
      sbq.push_back('{d: vecs[i].data, rs: vecs[i].rs});
      tick();
      enable_lcd = 1'b0;
      t_acc = cyc;
      chk("acc_data", {24'd0, lcd_data}, {24'd0, vecs[i].data});
      chk("acc_rs", {31'd0, lcd_rs}, {31'd0, vecs[i].rs});
      chk("acc_busy", {31'd0, busy}, 32'd1);
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
        tick();
        lat++;
      end
      chk("done_latency", lat, vecs[i].lat);
      chk("done_not_busy", {31'd0, busy}, 32'd0);
      chk("e_rise_offset", rise_cyc - t_acc, 2);
    end

    wait_idle();
    enable_lcd  = 1'b1;
    lcd_in_data = 8'h55;
    lcd_in_rs   = 1'b1;
    sbq.push_back('{d: 8'h55, rs: 1'b1});
    tick();
    enable_lcd = 1'b0;
    repeat (3) tick();
    enable_lcd  = 1'b1;
    lcd_in_data = 8'h99;
    lcd_in_rs   = 1'b0;
    tick();
    enable_lcd = 1'b0;
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    chk("ovr_data_kept", {24'd0, lcd_data}, 32'h55);
    chk("ovr_rs_kept", {31'd0, lcd_rs}, 32'd1);
    tick();
    chk("ovr_one_cycle", {31'd0, overrun}, 32'd0);
    repeat (4) tick();
    chk("ovr_no_early_done", {31'd0, done}, 32'd0);
    tick();
    chk("ovr_done_t11", {31'd0, done}, 32'd1);
    enable_lcd  = 1'b1;
    lcd_in_data = 8'h42;
    lcd_in_rs   = 1'b1;
    sbq.push_back('{d: 8'h42, rs: 1'b1});
    tick();
    enable_lcd = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_data", {24'd0, lcd_data}, 32'h42);
    chk("b2b_no_overrun", {31'd0, overrun}, 32'd0);
    wait_done("b2b_done");

    wait_idle();
    enable_lcd  = 1'b1;
    lcd_in_data = 8'h30;
    lcd_in_rs   = 1'b0;
    sbq.push_back('{d: 8'h30, rs: 1'b0});
    tick();
    enable_lcd = 1'b0;
    for (int k = 0; k < 20 && lcd_e !== 1'b1; k++) tick();
    chk("mid_e_seen", {31'd0, lcd_e}, 32'd1);
    rst         = 1'b1;
    enable_lcd  = 1'b1;
    lcd_in_data = 8'hFF;
    cut         = 1'b1;
    tick();
    rst        = 1'b0;
    enable_lcd = 1'b0;
    chk("mid_rst_e", {31'd0, lcd_e}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    chk("mid_rst_data", {24'd0, lcd_data}, 32'd0);
    chk("mid_rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    push_init();
    d0 = done_cnt;
    run_init(-1, n);
    chk("reinit_busy_len", n, 65);
    chk("reinit_no_done", done_cnt, d0);

    tick();
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
